// File: rtl/ysyx_23060201_imem_responder.sv
// Instruction-memory responder: one fetch in flight; word returned LATENCY cycles after the accept cycle.
// The response is held stable while resp_ready is low, and no new request is accepted until it is consumed.
module ysyx_23060201_imem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [31:0]              req_addr_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [31:0]              resp_data_o,
    output logic                     resp_err_o,
    input  logic                     ld_en_i,
    input  logic [$clog2(DEPTH)-1:0] ld_idx_i,
    input  logic [31:0]              ld_data_i
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          addr_ok;

    // BASE is word-aligned, so the low offset bits carry the alignment check and a
    // request below BASE wraps to a huge offset that fails the range check.
    assign off     = req_addr_i - BASE;
    assign idx     = off[AW+1:2];
    assign addr_ok = (off[1:0] == 2'b00) && (off[31:AW+2] == '0);

    // Preload port is independent of reset and of the fetch FSM.
    always_ff @(posedge clk_i) begin
        if (ld_en_i) begin
            mem_q[ld_idx_i] <= ld_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                // Snapshot taken here reads the pre-write word on an ld collision.
                if (req_valid_i) begin
                    data_d  = addr_ok ? mem_q[idx] : '0;
                    err_d   = ~addr_ok;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = data_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_23060201_imem_responder.sv
// Scoreboard bench: driver pushes expected responses at accept, monitor pops and compares them.
// Two extra instances with LATENCY 1 and 15 measure back-to-back accept spacing.
module tb_ysyx_23060201_imem_responder;
    localparam int unsigned   DEPTH  = 1024;
    localparam logic [31:0]   BASE   = 32'h8000_0000;
    localparam int            LAT_M  = 2;
    localparam longint unsigned BASE_L = 64'h8000_0000;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_i, req_valid_i, resp_ready_i, ld_en_i;
    logic        req_ready_o, resp_valid_o, resp_err_o;
    logic [31:0] req_addr_i, resp_data_o, ld_data_i;
    logic [9:0]  ld_idx_i;

    ysyx_23060201_imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT_M)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
        .ld_en_i(ld_en_i), .ld_idx_i(ld_idx_i), .ld_data_i(ld_data_i)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [DEPTH];
    exp_t        exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference: in-range, word-aligned byte addresses map to words; anything else is an error.
    function automatic exp_t model(input logic [31:0] a);
        longint unsigned la;
        exp_t e;
        la = 64'(a);
        e.acc = 0;
        if ((la % 4) != 0 || la < BASE_L || la >= BASE_L + 4 * DEPTH) begin
            e.err  = 1'b1;
            e.data = '0;
        end else begin
            e.err  = 1'b0;
            e.data = ref_mem[int'((la - BASE_L) / 4)];
        end
        return e;
    endfunction

    task automatic ld(input int idx, input logic [31:0] d);
        ld_en_i = 1'b1; ld_idx_i = 10'(idx); ld_data_i = d;
        @(posedge clk); #1;
        ref_mem[idx] = d;
        ld_en_i = 1'b0;
    endtask

    // One fetch; hold = cycles resp_valid stays high with resp_ready low.
    task automatic fetch(input logic [31:0] addr, input int hold, input bit cld,
                         input int cidx, input logic [31:0] cdat, input bit snap);
        exp_t e;
        int   n;
        int   sidx;
        logic [31:0] sdat;
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        resp_ready_i = (hold == 0);
        if (cld) begin
            ld_en_i = 1'b1; ld_idx_i = 10'(cidx); ld_data_i = cdat;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready_o) break;
            if (++n > 20) begin
                fail_now("accept_timeout");
                req_valid_i = 1'b0; ld_en_i = 1'b0;
                return;
            end
        end
        e = model(addr);
        e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (cld) ref_mem[cidx] = cdat;
        ld_en_i     = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        if (snap && !e.err) begin
            sidx = int'((64'(addr) - BASE_L) / 4);
            sdat = $urandom;
            ld_en_i = 1'b1; ld_idx_i = 10'(sidx); ld_data_i = sdat;
            @(posedge clk); #1;
            ref_mem[sidx] = sdat;
            ld_en_i = 1'b0;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (resp_valid_o) break;
            if (++n > 40) begin
                fail_now("resp_timeout");
                return;
            end
        end
        if (hold > 0) begin
            repeat (hold - 1) @(negedge clk);
            @(posedge clk); #1;
            resp_ready_i = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready_i = 1'($urandom_range(0, 1));
    endtask

    // Monitor: latency, data, error, stability under backpressure, and return to IDLE.
    initial begin : monitor
        bit          active;
        bit          prev_hs;
        logic [31:0] hd;
        logic        he;
        exp_t        e;
        active = 1'b0; prev_hs = 1'b0; hd = '0; he = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                active = 1'b0; prev_hs = 1'b0;
                continue;
            end
            if (prev_hs) begin
                chk("idle_after_hs_valid", 32'(resp_valid_o), 32'd0);
                chk("idle_after_hs_ready", 32'(req_ready_o), 32'd1);
            end
            prev_hs = 1'b0;
            if (resp_valid_o) begin
                chk("busy_req_ready", 32'(req_ready_o), 32'd0);
                if (!active) begin
                    if (exp_q.size() == 0) begin
                        fail_now("spurious_resp_valid");
                    end else begin
                        e = exp_q[0];
                        chk("latency", 32'(cyc - e.acc), 32'(LAT_M));
                        chk("resp_data", resp_data_o, e.data);
                        chk("resp_err", 32'(resp_err_o), 32'(e.err));
                        hd = e.data; he = e.err;
                        active = 1'b1;
                    end
                end else begin
                    chk("hold_data", resp_data_o, hd);
                    chk("hold_err", 32'(resp_err_o), 32'(he));
                end
                if (resp_ready_i) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    active  = 1'b0;
                    prev_hs = 1'b1;
                end
            end
        end
    end

    // Back-to-back sweep at the latency extremes.
    for (genvar g = 0; g < 2; g++) begin : g_sw
        localparam int LAT = (g == 0) ? 1 : 15;
        logic        rst, rv, rdy, pv, pr, pe, le, done;
        logic [31:0] ra, pd, lw;
        logic [9:0]  li;

        ysyx_23060201_imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) u_sw (
            .clk_i(clk), .rst_i(rst),
            .req_valid_i(rv), .req_ready_o(rdy), .req_addr_i(ra),
            .resp_valid_o(pv), .resp_ready_i(pr), .resp_data_o(pd), .resp_err_o(pe),
            .ld_en_i(le), .ld_idx_i(li), .ld_data_i(lw)
        );

        initial begin
            int last, nacc, got;
            bit acc;
            last = -1; nacc = 0; got = 0; done = 1'b0;
            rst = 1'b1; rv = 1'b0; ra = BASE; pr = 1'b1; le = 1'b0; li = '0; lw = '0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk); #1;
                le = 1'b1; li = 10'(k); lw = 32'h5A00_0000 + 32'(LAT << 16) + 32'(k);
            end
            @(posedge clk); #1;
            le = 1'b0; rst = 1'b0; rv = 1'b1;
            for (int t = 0; t < 400 && got < 8; t++) begin
                @(negedge clk);
                acc = rv && rdy;
                if (acc) begin
                    if (last >= 0) chk("sweep_spacing", 32'(cyc - last), 32'(LAT + 1));
                    last = cyc;
                    nacc++;
                end
                if (pv && pr) begin
                    chk("sweep_data", pd, 32'h5A00_0000 + 32'(LAT << 16) + 32'(got));
                    chk("sweep_err", 32'(pe), 32'd0);
                    got++;
                end
                @(posedge clk); #1;
                if (acc) begin
                    ra = BASE + 32'(4 * nacc);
                    if (nacc == 8) rv = 1'b0;
                end
            end
            if (got < 8) fail_now("sweep_timeout");
            done = 1'b1;
        end
    end

    initial begin : driver
        logic [31:0] a;
        int          hold;
        bit          cld, snap;
        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; resp_ready_i = 1'b0;
        ld_en_i = 1'b0; ld_idx_i = '0; ld_data_i = '0;
        // Whole array is preloaded while reset is held.
        for (int i = 0; i < DEPTH; i++) ld(i, $urandom);
        ld(0, 32'h0000_0413);
        ld(3, 32'h0010_0073);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_resp_data", resp_data_o, 32'd0);
        chk("rst_resp_err", 32'(resp_err_o), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        fetch(32'h8000_0000, 0, 1'b0, 0, '0, 1'b0);
        fetch(32'h8000_0000, 5, 1'b0, 0, '0, 1'b0);
        fetch(32'h8000_0002, 0, 1'b0, 0, '0, 1'b0);
        fetch(32'h7FFF_FFFC, 0, 1'b0, 0, '0, 1'b0);
        fetch(BASE + 32'(4 * DEPTH), 2, 1'b0, 0, '0, 1'b0);
        fetch(BASE + 32'(4 * (DEPTH - 1)), 0, 1'b0, 0, '0, 1'b0);
        fetch(32'h8000_000C, 0, 1'b1, 3, 32'hDEAD_BEEF, 1'b0);
        fetch(32'h8000_000C, 1, 1'b0, 0, '0, 1'b0);
        fetch(32'h8000_0000, 3, 1'b0, 0, '0, 1'b1);

        // Reset while the request sits in WAIT: no response may ever appear.
        req_valid_i = 1'b1; req_addr_i = 32'h8000_0004; resp_ready_i = 1'b1;
        @(negedge clk);
        chk("rstmid_accept_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0; rst_i = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_no_valid", 32'(resp_valid_o), 32'd0);
            chk("rstmid_ready", 32'(req_ready_o), 32'd1);
        end
        @(posedge clk); #1;
        fetch(32'h8000_0000, 0, 1'b0, 0, '0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 9))
                0: a = BASE + 32'($urandom_range(0, DEPTH - 1) << 2) + 32'($urandom_range(1, 3));
                1: a = BASE - 32'(4 * $urandom_range(1, 8));
                2: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
                default: a = BASE + 32'($urandom_range(0, DEPTH - 1) << 2);
            endcase
            hold = $urandom_range(0, 3);
            cld  = ($urandom_range(0, 3) == 0);
            snap = ($urandom_range(0, 3) == 0);
            fetch(a, hold, cld, $urandom_range(0, DEPTH - 1), $urandom, snap);
        end

        for (int i = 0; i < 3000 && !(g_sw[0].done && g_sw[1].done); i++) @(posedge clk);
        if (!(g_sw[0].done && g_sw[1].done)) fail_now("sweep_not_done");
        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) fail_now("scoreboard_not_empty");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
